// File: rtl/alu_execute_stage_if.sv
// Instruction handshake between the issue logic and the ALU execute stage.
// The master offers one instruction; the slave (execute stage) accepts it with in_ready.
interface alu_execute_stage_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_opcode;
    logic [2:0] in_rd;
    logic [2:0] in_rs;
    logic [3:0] in_imm;

    modport master (
        output in_valid, in_opcode, in_rd, in_rs, in_imm,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_opcode, in_rd, in_rs, in_imm,
        output in_ready
    );
endinterface

// File: rtl/alu_execute_stage.sv
// Three-cycle execute stage: IDLE accepts, EXEC drives the external ALU, WB retires.
// Holds an 8x4-bit register file (R0 hard-wired to zero) and the architectural flags.
module alu_execute_stage (
    input  logic               clk,
    input  logic               rst,
    alu_execute_stage_if.slave inst,
    output logic [3:0]         alu_opcode,
    output logic [3:0]         alu_a,
    output logic [3:0]         alu_b,
    input  logic [3:0]         alu_o,
    input  logic [7:0]         alu_flags,
    output logic [7:0]         flags,
    output logic               done,
    input  logic [2:0]         dbg_addr,
    output logic [3:0]         dbg_data
);
    localparam logic [3:0] OP_LDI = 4'b1001;
    localparam logic [3:0] OP_ADI = 4'b1010;
    localparam logic [3:0] OP_CMP = 4'b1101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic [3:0] opcode_reg;
    logic [2:0] rd_reg;
    logic [2:0] rs_reg;
    logic [3:0] imm_reg;
    logic [3:0] result_reg;
    logic [7:0] alu_flags_reg;
    logic [7:0] flags_reg;
    logic [3:0] regs_reg [8];

    logic       accept;
    logic       commit;
    logic       writes_rd;
    logic       updates_flags;
    logic [7:0] wr_sel;

    assign inst.in_ready = (state_reg == IDLE) && !rst;
    assign accept        = inst.in_valid && inst.in_ready;
    assign commit        = (state_reg == WB);

    // Opcodes 1..10 produce a register result; CMP only produces flags, LDI only a result.
    assign writes_rd     = (opcode_reg >= 4'd1) && (opcode_reg <= 4'd10);
    assign updates_flags = ((opcode_reg >= 4'd1) && (opcode_reg <= 4'd8))
                           || (opcode_reg == OP_ADI) || (opcode_reg == OP_CMP);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            opcode_reg    <= '0;
            rd_reg        <= '0;
            rs_reg        <= '0;
            imm_reg       <= '0;
            result_reg    <= '0;
            alu_flags_reg <= '0;
            flags_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                opcode_reg <= inst.in_opcode;
                rd_reg     <= inst.in_rd;
                rs_reg     <= inst.in_rs;
                imm_reg    <= inst.in_imm;
            end
            if (state_reg == EXEC) begin
                result_reg    <= alu_o;
                alu_flags_reg <= alu_flags;
            end
            if (commit && updates_flags) begin
                flags_reg <= alu_flags_reg;
            end
        end
    end

    // Per-register write strobes; R0 never gets one, so it stays at its reset value of zero.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_wr_sel
            if (gi == 0) begin : g_r0
                assign wr_sel[gi] = 1'b0;
            end else begin : g_rn
                assign wr_sel[gi] = commit && writes_rd && (rd_reg == 3'(gi));
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (wr_sel[i]) begin
                    regs_reg[i] <= result_reg;
                end
            end
        end
    end

    always_comb begin
        alu_opcode = '0;
        alu_a      = '0;
        alu_b      = '0;
        if (state_reg == EXEC) begin
            alu_opcode = opcode_reg;
            case (opcode_reg)
                OP_LDI: begin
                    alu_a = '0;
                    alu_b = imm_reg;
                end
                OP_ADI: begin
                    alu_a = regs_reg[rd_reg];
                    alu_b = imm_reg;
                end
                default: begin
                    alu_a = regs_reg[rd_reg];
                    alu_b = regs_reg[rs_reg];
                end
            endcase
        end
    end

    assign flags    = flags_reg;
    assign done     = (state_reg == WB);
    assign dbg_data = regs_reg[dbg_addr];
endmodule

// File: tb/tb_alu_execute_stage.sv
// Bench for alu_execute_stage: a behavioural ALU drives alu_o/alu_flags, and an architectural
// model (register array + flags) predicts every retired instruction.
module tb_alu_execute_stage;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] alu_opcode, alu_a, alu_b, alu_o;
    logic [7:0] alu_flags, flags;
    logic       done;
    logic [2:0] dbg_addr;
    logic [3:0] dbg_data;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [3:0] m_r [8];
    logic [7:0] m_flags;

    alu_execute_stage_if inst_bus ();

    alu_execute_stage dut (
        .clk        (clk),
        .rst        (rst),
        .inst       (inst_bus),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_o      (alu_o),
        .alu_flags  (alu_flags),
        .flags      (flags),
        .done       (done),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    always #5 clk = ~clk;

    // External ALU: returns {flags[7:0], result[3:0]}; flags = {LT,GT,NE,EQ,V,N,C,Z}.
    function automatic logic [11:0] alu_fn(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        logic [3:0] o;
        logic       c, v;
        s = '0; c = 1'b0; v = 1'b0;
        case (op)
            4'd1, 4'd9, 4'd10: begin
                s = {1'b0, a} + {1'b0, b};
                o = s[3:0]; c = s[4];
                v = (a[3] == b[3]) && (o[3] != a[3]);
            end
            4'd2, 4'd13: begin
                s = {1'b0, a} + {1'b0, ~b} + 5'd1;
                o = s[3:0]; c = s[4];
                v = (a[3] != b[3]) && (o[3] != a[3]);
            end
            4'd3: o = a & b;
            4'd4: o = a | b;
            4'd5: o = a ^ b;
            4'd6: begin o = {a[2:0], 1'b0}; c = a[3]; end
            4'd7: begin o = {1'b0, a[3:1]}; c = a[0]; end
            4'd8: o = ~a;
            default: o = a ^ 4'h5;
        endcase
        return {(a < b), (a > b), (a != b), (a == b), v, o[3], c, (o == 4'd0), o};
    endfunction

    always_comb {alu_flags, alu_o} = alu_fn(alu_opcode, alu_a, alu_b);

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = 4'd0;
        m_flags = 8'd0;
    endtask

    // Architectural effect of one retired instruction; also returns the expected ALU operands.
    task automatic model_exec(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                              input logic [3:0] imm, output logic [3:0] ea, output logic [3:0] eb);
        logic [11:0] r;
        ea = (op == 4'd9) ? 4'd0 : m_r[rd];
        eb = (op == 4'd9 || op == 4'd10) ? imm : m_r[rs];
        r  = alu_fn(op, ea, eb);
        if (op >= 4'd1 && op <= 4'd10 && rd != 3'd0) m_r[rd] = r[3:0];
        if ((op >= 4'd1 && op <= 4'd8) || op == 4'd10 || op == 4'd13) m_flags = r[11:4];
    endtask

    // Offer one instruction starting at a negedge; observe the three cycles after acceptance.
    // Returns at the negedge where the block is idle again.
    task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [3:0] imm, output bit accepted, output logic [2:0] done_mask,
                         output logic [2:0] ready_mask, output logic [11:0] alu_exec,
                         output logic [11:0] alu_wb, output time acc_time);
        accepted = 1'b0; done_mask = '0; ready_mask = '0; alu_exec = '0; alu_wb = '0; acc_time = 0;
        inst_bus.in_opcode = op;
        inst_bus.in_rd     = rd;
        inst_bus.in_rs     = rs;
        inst_bus.in_imm    = imm;
        inst_bus.in_valid  = 1'b1;
        for (int t = 0; t < 8 && !accepted; t++) begin
            #1;
            if (inst_bus.in_ready) accepted = 1'b1;
            @(posedge clk);
            if (accepted) acc_time = $time;
            else @(negedge clk);
        end
        #1 inst_bus.in_valid = 1'b0;
        if (accepted) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                done_mask[k]  = done;
                ready_mask[k] = inst_bus.in_ready;
                if (k == 0) alu_exec = {alu_opcode, alu_a, alu_b};
                if (k == 1) alu_wb   = {alu_opcode, alu_a, alu_b};
            end
        end else begin
            @(negedge clk);
        end
        $display("instr op=%h rd=%0d rs=%0d imm=%h accepted=%0d done_mask=%b t=%0t",
                 op, rd, rs, imm, accepted, done_mask, acc_time);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        inst_bus.in_valid = 1'b1; inst_bus.in_opcode = 4'd9; inst_bus.in_rd = 3'd1;
        inst_bus.in_rs = 3'd0; inst_bus.in_imm = 4'd7; dbg_addr = 3'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++; if (inst_bus.in_ready !== 1'b0) $display("FAIL reset_ready_low got %b want 0", inst_bus.in_ready); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
        total_cnt++; if (flags !== 8'h00) $display("FAIL reset_flags got %h want 00", flags); else pass_cnt++;
        total_cnt++; if ({alu_opcode, alu_a, alu_b} !== 12'h000) $display("FAIL reset_alu_bus got %h want 000", {alu_opcode, alu_a, alu_b}); else pass_cnt++;
        rst = 1'b0;
        inst_bus.in_valid = 1'b0;
        #1;
        total_cnt++; if (inst_bus.in_ready !== 1'b1) $display("FAIL reset_ready_after got %b want 1", inst_bus.in_ready); else pass_cnt++;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i); #1;
            total_cnt++; if (dbg_data !== 4'd0) $display("FAIL reset_reg R%0d got %h want 0", i, dbg_data); else pass_cnt++;
        end
        @(negedge clk);
    endtask

    task automatic test_add();
        logic [3:0] ops [3] = '{4'd9, 4'd9, 4'd1};
        logic [2:0] rds [3] = '{3'd1, 3'd2, 3'd1};
        logic [2:0] rss [3] = '{3'd0, 3'd0, 3'd2};
        logic [3:0] ims [3] = '{4'd7, 4'd9, 4'd0};
        bit acc; logic [2:0] dm, rm; logic [11:0] ae, aw; time at, prev; logic [3:0] ea, eb;
        prev = 0;
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], rds[i], rss[i], ims[i], acc, dm, rm, ae, aw, at);
            model_exec(ops[i], rds[i], rss[i], ims[i], ea, eb);
            total_cnt++; if (acc !== 1'b1 || dm !== 3'b010) $display("FAIL add_done_pulse[%0d] got acc=%b mask=%b want 1/010", i, acc, dm); else pass_cnt++;
            total_cnt++; if (ae !== {ops[i], ea, eb}) $display("FAIL add_alu_exec[%0d] got %h want %h", i, ae, {ops[i], ea, eb}); else pass_cnt++;
            if (i > 0) begin
                total_cnt++; if (at - prev !== 30) $display("FAIL add_spacing[%0d] got %0t want 30", i, at - prev); else pass_cnt++;
            end
            prev = at;
        end
        dbg_addr = 3'd1; #1;
        total_cnt++; if (dbg_data !== 4'd0) $display("FAIL add_r1 got %h want 0", dbg_data); else pass_cnt++;
        total_cnt++; if (flags !== 8'hA3) $display("FAIL add_flags got %h want a3", flags); else pass_cnt++;
        dbg_addr = 3'd2; #1;
        total_cnt++; if (dbg_data !== 4'd9) $display("FAIL add_r2 got %h want 9", dbg_data); else pass_cnt++;
    endtask

    task automatic test_cmp_ldi();
        logic [3:0] ops [4] = '{4'd9, 4'd9, 4'd13, 4'd9};
        logic [2:0] rds [4] = '{3'd3, 3'd4, 3'd3, 3'd5};
        logic [2:0] rss [4] = '{3'd0, 3'd0, 3'd4, 3'd0};
        logic [3:0] ims [4] = '{4'd5, 4'd5, 4'd0, 4'hF};
        bit acc; logic [2:0] dm, rm; logic [11:0] ae, aw; time at; logic [3:0] ea, eb;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], rds[i], rss[i], ims[i], acc, dm, rm, ae, aw, at);
            model_exec(ops[i], rds[i], rss[i], ims[i], ea, eb);
            if (i == 2) begin
                total_cnt++; if (flags !== 8'h13) $display("FAIL cmp_flags got %h want 13", flags); else pass_cnt++;
            end
        end
        dbg_addr = 3'd3; #1;
        total_cnt++; if (dbg_data !== 4'd5) $display("FAIL cmp_r3 got %h want 5", dbg_data); else pass_cnt++;
        dbg_addr = 3'd4; #1;
        total_cnt++; if (dbg_data !== 4'd5) $display("FAIL cmp_r4 got %h want 5", dbg_data); else pass_cnt++;
        dbg_addr = 3'd5; #1;
        total_cnt++; if (dbg_data !== 4'hF) $display("FAIL ldi_r5 got %h want f", dbg_data); else pass_cnt++;
        total_cnt++; if (flags !== 8'h13) $display("FAIL ldi_keeps_flags got %h want 13", flags); else pass_cnt++;
    endtask

    task automatic test_r0_nop();
        bit acc; logic [2:0] dm, rm; logic [11:0] ae, aw; time at; logic [3:0] ea, eb;
        issue(4'd9, 3'd0, 3'd0, 4'hF, acc, dm, rm, ae, aw, at);
        model_exec(4'd9, 3'd0, 3'd0, 4'hF, ea, eb);
        dbg_addr = 3'd0; #1;
        total_cnt++; if (dbg_data !== 4'd0) $display("FAIL r0_write got %h want 0", dbg_data); else pass_cnt++;
        total_cnt++; if (dm !== 3'b010) $display("FAIL r0_done got %b want 010", dm); else pass_cnt++;
        issue(4'hF, 3'd3, 3'd5, 4'd0, acc, dm, rm, ae, aw, at);
        model_exec(4'hF, 3'd3, 3'd5, 4'd0, ea, eb);
        total_cnt++; if (dm !== 3'b010) $display("FAIL nop_done got %b want 010", dm); else pass_cnt++;
        total_cnt++; if (flags !== m_flags) $display("FAIL nop_flags got %h want %h", flags, m_flags); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i); #1;
            total_cnt++; if (dbg_data !== m_r[i]) $display("FAIL nop_reg R%0d got %h want %h", i, dbg_data, m_r[i]); else pass_cnt++;
        end
    endtask

    task automatic test_hold_valid();
        bit acc; logic [2:0] dm, rm; logic [11:0] ae, aw; time at; logic [3:0] ea, eb;
        int acc_cnt, done_cnt; logic [5:0] ready_pat;
        issue(4'd9, 3'd1, 3'd0, 4'd2, acc, dm, rm, ae, aw, at);
        model_exec(4'd9, 3'd1, 3'd0, 4'd2, ea, eb);
        acc_cnt = 0; done_cnt = 0; ready_pat = '0;
        inst_bus.in_opcode = 4'd10; inst_bus.in_rd = 3'd1; inst_bus.in_rs = 3'd6; inst_bus.in_imm = 4'd3;
        inst_bus.in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            ready_pat[c] = inst_bus.in_ready;
            if (inst_bus.in_ready) acc_cnt++;
            if (done) done_cnt++;
            @(negedge clk);
        end
        inst_bus.in_valid = 1'b0;
        $display("instr hold-valid ADI R1,3 acceptances=%0d ready=%b", acc_cnt, ready_pat);
        for (int j = 0; j < acc_cnt; j++) model_exec(4'd10, 3'd1, 3'd6, 4'd3, ea, eb);
        total_cnt++; if (acc_cnt !== 2) $display("FAIL hold_acceptances got %0d want 2", acc_cnt); else pass_cnt++;
        total_cnt++; if (ready_pat !== 6'b001001) $display("FAIL hold_ready_pattern got %b want 001001", ready_pat); else pass_cnt++;
        total_cnt++; if (done_cnt !== 2) $display("FAIL hold_done_count got %0d want 2", done_cnt); else pass_cnt++;
        dbg_addr = 3'd1; #1;
        total_cnt++; if (dbg_data !== 4'd8 || dbg_data !== m_r[1]) $display("FAIL hold_r1 got %h want 8", dbg_data); else pass_cnt++;
        total_cnt++; if (flags !== m_flags) $display("FAIL hold_flags got %h want %h", flags, m_flags); else pass_cnt++;
    endtask

    // Reset pulsed while LDI R6,4 sits in EXEC (phase 1) or WB (phase 2).
    task automatic test_reset_abort();
        bit acc; logic [2:0] dm, rm; logic [11:0] ae, aw; time at; logic [3:0] ea, eb;
        int done_cnt;
        for (int phase = 1; phase <= 2; phase++) begin
            issue(4'd9, 3'd1, 3'd0, 4'd9, acc, dm, rm, ae, aw, at);
            issue(4'd10, 3'd1, 3'd0, 4'd1, acc, dm, rm, ae, aw, at);
            inst_bus.in_opcode = 4'd9; inst_bus.in_rd = 3'd6; inst_bus.in_rs = 3'd0; inst_bus.in_imm = 4'd4;
            inst_bus.in_valid = 1'b1;
            @(posedge clk);
            #1 inst_bus.in_valid = 1'b0;
            repeat (phase) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            model_reset();
            #1;
            $display("instr LDI R6,4 aborted by reset in phase %0d", phase);
            total_cnt++; if (inst_bus.in_ready !== 1'b1) $display("FAIL abort_ready[%0d] got %b want 1", phase, inst_bus.in_ready); else pass_cnt++;
            total_cnt++; if (flags !== 8'h00) $display("FAIL abort_flags[%0d] got %h want 00", phase, flags); else pass_cnt++;
            dbg_addr = 3'd6; #1;
            total_cnt++; if (dbg_data !== 4'd0) $display("FAIL abort_r6[%0d] got %h want 0", phase, dbg_data); else pass_cnt++;
            dbg_addr = 3'd1; #1;
            total_cnt++; if (dbg_data !== 4'd0) $display("FAIL abort_r1[%0d] got %h want 0", phase, dbg_data); else pass_cnt++;
            done_cnt = 0;
            for (int c = 0; c < 4; c++) begin
                if (done) done_cnt++;
                @(negedge clk);
            end
            total_cnt++; if (done_cnt !== 0) $display("FAIL abort_no_done[%0d] got %0d want 0", phase, done_cnt); else pass_cnt++;
        end
    endtask

    task automatic test_random();
        bit acc; logic [2:0] dm, rm; logic [11:0] ae, aw; time at; logic [3:0] ea, eb;
        logic [3:0] op, imm; logic [2:0] rd, rs;
        for (int n = 0; n < 40; n++) begin
            op  = 4'($urandom_range(0, 15));
            rd  = 3'($urandom_range(0, 7));
            rs  = 3'($urandom_range(0, 7));
            imm = 4'($urandom_range(0, 15));
            if (n < 6) op = 4'd9;
            issue(op, rd, rs, imm, acc, dm, rm, ae, aw, at);
            model_exec(op, rd, rs, imm, ea, eb);
            total_cnt++; if (acc !== 1'b1 || dm !== 3'b010 || rm !== 3'b100) $display("FAIL rand_handshake[%0d] got acc=%b done=%b ready=%b want 1/010/100", n, acc, dm, rm); else pass_cnt++;
            total_cnt++; if (ae !== {op, ea, eb}) $display("FAIL rand_alu_exec[%0d] got %h want %h", n, ae, {op, ea, eb}); else pass_cnt++;
            total_cnt++; if (aw !== 12'h000) $display("FAIL rand_alu_wb[%0d] got %h want 000", n, aw); else pass_cnt++;
            total_cnt++; if (flags !== m_flags) $display("FAIL rand_flags[%0d] got %h want %h", n, flags, m_flags); else pass_cnt++;
            dbg_addr = rd; #1;
            total_cnt++; if (dbg_data !== m_r[rd]) $display("FAIL rand_reg[%0d] R%0d got %h want %h", n, rd, dbg_data, m_r[rd]); else pass_cnt++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_add();
        test_cmp_ldi();
        test_r0_nop();
        test_hold_valid();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
